// File: rtl/hs_const_pkg.sv
// Shared definitions for the handshake constant sequencer: mode selectors,
// burst FSM state encoding and an index-width helper.
package hs_const_pkg;

  localparam int unsigned MODE_SINGLE = 0;
  localparam int unsigned MODE_BURST  = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } hs_const_state_e;

  // Index width that stays at least one bit wide for single-entry tables.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_const_outreg.sv
// Single-slot elastic output register. Holds data, valid and (with
// HS_CONST_LAST_EN defined) the last flag, and reports when a new entry may load.
module hs_const_outreg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
`ifdef HS_CONST_LAST_EN
  input  logic                  last_i,
  output logic                  last_o,
`endif
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  slot_free_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // Slot can take a new entry when empty or when the current one drains this cycle.
  always_comb begin
    slot_free_o = !valid_q || ready_i;
  end

  // Load a new entry, or clear valid once the held entry is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef HS_CONST_LAST_EN
  logic last_q;

  // Last flag travels with the data it describes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b0;
    end else if (load_i) begin
      last_q <= last_i;
    end
  end

  assign last_o = last_q;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/handshake_constant_seq.sv
// Elastic constant sequencer: emits entries of a compile-time table, either one
// per ctrl token (MODE 0, cycling) or a full burst per token (MODE 1).
// Optional feature: define HS_CONST_LAST_EN to add the outs_last port.
module handshake_constant_seq
  import hs_const_pkg::*;
#(
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter int unsigned                  DEPTH      = 4,
  parameter int unsigned                  MODE       = 0,
  parameter logic [DATA_WIDTH*DEPTH-1:0]  TABLE      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
`ifdef HS_CONST_LAST_EN
  output logic                  outs_last,
`endif
  input  logic                  outs_ready
);

  localparam int unsigned          IDX_W    = clog2_min1(DEPTH);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DEPTH - 1);
  // A one-entry burst is just a single emission, so it reuses the MODE 0 path.
  localparam bit                   BURST_EN = (MODE == MODE_BURST) && (DEPTH > 1);

  logic [IDX_W-1:0]      idx_q, idx_d;
  hs_const_state_e       state_q;
  logic [DATA_WIDTH-1:0] entry;
  logic                  slot_free;
  logic                  load;

  // Table lookup and wrapping index successor; no power-of-2 assumption on DEPTH.
  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        entry = TABLE[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Tokens are taken only in IDLE; during a burst the FSM loads on its own.
  always_comb begin
    ctrl_ready = slot_free && (state_q == ST_IDLE);
    load       = (state_q == ST_BURST) ? slot_free : (ctrl_valid && slot_free);
  end

  // Index counter and burst FSM; idx is always 0 in IDLE when bursting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else if (load) begin
      idx_q <= idx_d;
      if (BURST_EN) begin
        unique case (state_q)
          ST_IDLE:  state_q <= ST_BURST;
          ST_BURST: if (idx_q == IDX_LAST) state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  hs_const_outreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outreg (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .data_i      (entry),
`ifdef HS_CONST_LAST_EN
    .last_i      (idx_q == IDX_LAST),
    .last_o      (outs_last),
`endif
    .ready_i     (outs_ready),
    .data_o      (outs),
    .valid_o     (outs_valid),
    .slot_free_o (slot_free)
  );

endmodule
